// File: rtl/dac_output_conditioner.sv
// Per-channel offset, min/max clamp and slew limit ahead of the AD9117 DAC driver; 3-stage pipeline.
// Optional saturation counters at 0xA/0xB are built when DAC_COND_SAT_CNT_EN is defined.
module dac_output_conditioner #(
    parameter logic [7:0] GET_PREFIX = 8'h22,
    parameter logic [7:0] SET_PREFIX = 8'h23,
    parameter logic [1:0] CTRL_RESET = 2'b11
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cmd_trig_in,
    input  logic [15:0]        cmd_addr_in,
    input  logic [15:0]        cmd_data_in,
    output logic [15:0]        cmd_data_out,
    input  logic signed [15:0] ch0_in,
    input  logic signed [15:0] ch1_in,
    output logic signed [15:0] DAC0_out,
    output logic signed [15:0] DAC1_out,
    output logic [1:0]         sat_out
);
    localparam int DATA_W = 16;
    localparam int SUM_W  = DATA_W + 1;

    logic signed [DATA_W-1:0] offset_r [2];
    logic signed [DATA_W-1:0] min_r [2];
    logic signed [DATA_W-1:0] max_r [2];
    logic [DATA_W-1:0]        step_r [2];
    logic [1:0]               ctrl_r;
    logic [1:0]               status_r;
    logic [15:0]              sat_cnt_rd [2];
    logic [15:0]              rd_data;

    logic signed [DATA_W-1:0] ch_in [2];
    logic signed [SUM_W-1:0]  sum_p0 [2];
    logic signed [DATA_W-1:0] clamp_v [2];
    logic [1:0]               clamp_hit;
    logic signed [DATA_W-1:0] target_p1 [2];
    logic [1:0]               sat_p1;
    logic signed [DATA_W-1:0] out_p2 [2];
    logic [1:0]               sat_p2;

    logic       set_hit;
    logic       get_hit;
    logic [3:0] idx;
    logic [1:0] status_clr;
    logic       unused_addr_bits;

    assign set_hit    = cmd_trig_in && (cmd_addr_in[15:8] == SET_PREFIX);
    assign get_hit    = cmd_trig_in && (cmd_addr_in[15:8] == GET_PREFIX);
    assign idx        = cmd_addr_in[3:0];
    assign status_clr = (set_hit && idx == 4'h9) ? cmd_data_in[1:0] : 2'b00;
    assign unused_addr_bits = ^cmd_addr_in[7:4];

    assign ch_in[0] = ch0_in;
    assign ch_in[1] = ch1_in;

    // MAX is applied before MIN, so an inverted window resolves to MIN.
    function automatic logic signed [DATA_W-1:0] clamp_fn(
        input logic signed [SUM_W-1:0]  sum,
        input logic signed [DATA_W-1:0] lo,
        input logic signed [DATA_W-1:0] hi
    );
        logic signed [SUM_W-1:0] t;
        logic signed [SUM_W-1:0] lo_x;
        logic signed [SUM_W-1:0] hi_x;
        lo_x = {lo[DATA_W-1], lo};
        hi_x = {hi[DATA_W-1], hi};
        t = sum;
        if (t > hi_x) t = hi_x;
        if (t < lo_x) t = lo_x;
        return t[DATA_W-1:0];
    endfunction

    // Moves at most one step toward target; the difference is taken in 17 bits so it never wraps.
    function automatic logic signed [DATA_W-1:0] slew_fn(
        input logic signed [DATA_W-1:0] target,
        input logic signed [DATA_W-1:0] cur,
        input logic [DATA_W-1:0]        step
    );
        logic [DATA_W-1:0]       st;
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] d;
        logic signed [SUM_W-1:0] cur_x;
        logic signed [SUM_W-1:0] r;
        st    = step[DATA_W-1] ? 16'h7FFF : step;
        s     = {1'b0, st};
        cur_x = {cur[DATA_W-1], cur};
        d     = {target[DATA_W-1], target} - cur_x;
        r     = {target[DATA_W-1], target};
        if (st != '0) begin
            if (d > s)       r = cur_x + s;
            else if (d < -s) r = cur_x - s;
        end
        return r[DATA_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            clamp_v[c]   = clamp_fn(sum_p0[c], min_r[c], max_r[c]);
            clamp_hit[c] = ({clamp_v[c][DATA_W-1], clamp_v[c]} != sum_p0[c]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int c = 0; c < 2; c++) begin
                offset_r[c] <= '0;
                min_r[c]    <= 16'sh8000;
                max_r[c]    <= 16'sh7FFF;
                step_r[c]   <= '0;
            end
            ctrl_r   <= CTRL_RESET;
            status_r <= '0;
        end else begin
            if (set_hit && !idx[3]) begin
                case (idx[1:0])
                    2'd0:    offset_r[idx[2]] <= cmd_data_in;
                    2'd1:    min_r[idx[2]]    <= cmd_data_in;
                    2'd2:    max_r[idx[2]]    <= cmd_data_in;
                    default: step_r[idx[2]]   <= cmd_data_in;
                endcase
            end
            if (set_hit && idx == 4'h8) ctrl_r <= cmd_data_in[1:0];
            // A new saturation event overrides a simultaneous clear.
            status_r <= (status_r & ~status_clr) | sat_p1;
        end
    end

`ifdef DAC_COND_SAT_CNT_EN
    logic [15:0] sat_cnt_r [2];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sat_cnt_r[0] <= '0;
            sat_cnt_r[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (set_hit && idx == (4'hA + 4'(c)))
                    sat_cnt_r[c] <= '0;
                else if (sat_p1[c] && sat_cnt_r[c] != 16'hFFFF)
                    sat_cnt_r[c] <= sat_cnt_r[c] + 16'd1;
            end
        end
    end

    assign sat_cnt_rd[0] = sat_cnt_r[0];
    assign sat_cnt_rd[1] = sat_cnt_r[1];
`else
    assign sat_cnt_rd[0] = '0;
    assign sat_cnt_rd[1] = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (!idx[3]) begin
            case (idx[1:0])
                2'd0:    rd_data = offset_r[idx[2]];
                2'd1:    rd_data = min_r[idx[2]];
                2'd2:    rd_data = max_r[idx[2]];
                default: rd_data = step_r[idx[2]];
            endcase
        end else begin
            case (idx[2:0])
                3'd0:    rd_data = {14'd0, ctrl_r};
                3'd1:    rd_data = {14'd0, status_r};
                3'd2:    rd_data = sat_cnt_rd[0];
                3'd3:    rd_data = sat_cnt_rd[1];
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)      cmd_data_out <= '0;
        else if (get_hit) cmd_data_out <= rd_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int c = 0; c < 2; c++) begin
                sum_p0[c]    <= '0;
                target_p1[c] <= '0;
                out_p2[c]    <= '0;
            end
            sat_p1 <= '0;
            sat_p2 <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                // Stage 1: offset add
                sum_p0[c]    <= {ch_in[c][DATA_W-1], ch_in[c]} + {offset_r[c][DATA_W-1], offset_r[c]};
                // Stage 2: clamp / channel enable
                target_p1[c] <= ctrl_r[c] ? clamp_v[c] : '0;
                sat_p1[c]    <= ctrl_r[c] && clamp_hit[c];
                // Stage 3: slew limit
                out_p2[c]    <= slew_fn(target_p1[c], out_p2[c], step_r[c]);
            end
            sat_p2 <= sat_p1;
        end
    end

    assign DAC0_out = out_p2[0];
    assign DAC1_out = out_p2[1];
    assign sat_out  = sat_p2;

endmodule

// File: tb/tb_dac_output_conditioner.sv
// Directed, table-driven bench for dac_output_conditioner (default build or DAC_COND_SAT_CNT_EN).
module tb_dac_output_conditioner;
    localparam logic [7:0] GETP = 8'h22;
    localparam logic [7:0] SETP = 8'h23;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               cmd_trig_in;
    logic [15:0]        cmd_addr_in;
    logic [15:0]        cmd_data_in;
    logic [15:0]        cmd_data_out;
    logic signed [15:0] ch0_in;
    logic signed [15:0] ch1_in;
    logic signed [15:0] DAC0_out;
    logic signed [15:0] DAC1_out;
    logic [1:0]         sat_out;

    int n_checks = 0;
    int n_errors = 0;

    dac_output_conditioner dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cmd_trig_in (cmd_trig_in),
        .cmd_addr_in (cmd_addr_in),
        .cmd_data_in (cmd_data_in),
        .cmd_data_out(cmd_data_out),
        .ch0_in      (ch0_in),
        .ch1_in      (ch1_in),
        .DAC0_out    (DAC0_out),
        .DAC1_out    (DAC1_out),
        .sat_out     (sat_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] off0;
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [1:0]  exp_sat;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [7:0] pre, input logic [3:0] idx, input logic [15:0] d);
        @(negedge clk_in);
        cmd_trig_in = 1'b1;
        cmd_addr_in = {pre, 4'h0, idx};
        cmd_data_in = d;
        @(posedge clk_in);
        #1;
        cmd_trig_in = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] idx, input logic [15:0] exp);
        cmd(GETP, idx, 16'h0000);
        check(name, cmd_data_out, exp);
    endtask

    logic [15:0] ramp_up [5];
    logic [15:0] ramp_dn [4];
    logic [15:0] cnt_exp;

    initial begin
        tbl[0] = '{16'h0000, 16'h1234, 16'h0100, 16'h1234, 16'h0100, 2'b00};
        tbl[1] = '{16'h7000, 16'h2000, 16'h0300, 16'h7FFF, 16'h0200, 2'b11};
        tbl[2] = '{16'h8000, 16'h8000, 16'hFE00, 16'h8000, 16'hFF00, 2'b11};
        tbl[3] = '{16'hFFFF, 16'h0005, 16'hFF00, 16'h0004, 16'hFF00, 2'b00};
        tbl[4] = '{16'h0100, 16'h7F00, 16'h0200, 16'h7FFF, 16'h0200, 2'b01};
        tbl[5] = '{16'h0010, 16'hFFF0, 16'h8000, 16'h0000, 16'hFF00, 2'b10};
        ramp_up = '{16'h0010, 16'h0020, 16'h0030, 16'h0035, 16'h0035};
        ramp_dn = '{16'h0025, 16'h0015, 16'h0005, 16'h0000};
`ifdef DAC_COND_SAT_CNT_EN
        cnt_exp = 16'd5;
`else
        cnt_exp = 16'd0;
`endif

        rst_in = 1'b0;
        cmd_trig_in = 1'b0;
        cmd_addr_in = '0;
        cmd_data_in = '0;
        ch0_in = 16'sh5555;
        ch1_in = 16'sh1111;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_dac0", DAC0_out, 16'h0000);
        check("rst_dac1", DAC1_out, 16'h0000);
        check("rst_sat", {14'd0, sat_out}, 16'h0000);
        check("rst_cmd_data", cmd_data_out, 16'h0000);
        @(negedge clk_in);
        ch0_in = 16'sh0000;
        ch1_in = 16'sh0000;
        rst_in = 1'b1;
        repeat (4) @(posedge clk_in);

        // Three-edge latency
        @(negedge clk_in);
        ch0_in = 16'sh1234;
        @(posedge clk_in);
        @(posedge clk_in);
        #1 check("latency_edge2", DAC0_out, 16'h0000);
        @(posedge clk_in);
        #1 check("latency_edge3", DAC0_out, 16'h1234);
        rd_check("rd_ctrl_reset", 4'h8, 16'h0003);
        rd_check("rd_max0_reset", 4'h2, 16'h7FFF);

        // Steady-state vectors; ch1 window is [FF00, 0200]
        cmd(SETP, 4'h5, 16'hFF00);
        cmd(SETP, 4'h6, 16'h0200);
        for (int i = 0; i < 6; i++) begin
            cmd(SETP, 4'h0, tbl[i].off0);
            @(negedge clk_in);
            ch0_in = tbl[i].ch0;
            ch1_in = tbl[i].ch1;
            repeat (4) @(posedge clk_in);
            #1;
            check($sformatf("vec%0d_dac0", i), DAC0_out, tbl[i].exp0);
            check($sformatf("vec%0d_dac1", i), DAC1_out, tbl[i].exp1);
            check($sformatf("vec%0d_sat", i), {14'd0, sat_out}, {14'd0, tbl[i].exp_sat});
        end

        // Sticky status and write-1-to-clear against live saturation
        cmd(SETP, 4'h0, 16'h7000);
        @(negedge clk_in);
        ch0_in = 16'sh2000;
        ch1_in = 16'sh0000;
        repeat (4) @(posedge clk_in);
        rd_check("status_set", 4'h9, 16'h0003);
        cmd(SETP, 4'h9, 16'h0001);
        rd_check("status_clr_while_sat", 4'h9, 16'h0003);
        @(negedge clk_in);
        ch0_in = 16'sh0000;
        repeat (4) @(posedge clk_in);
        cmd(SETP, 4'h9, 16'h0003);
        rd_check("status_clr_in_range", 4'h9, 16'h0000);
        cmd(SETP, 4'h0, 16'h0000);

        // Inverted window: MIN wins
        cmd(SETP, 4'h5, 16'h0100);
        cmd(SETP, 4'h6, 16'h00F0);
        repeat (4) @(posedge clk_in);
        #1;
        check("minmax_dac1", DAC1_out, 16'h0100);
        check("minmax_sat", {14'd0, sat_out}, 16'h0002);

        // Slew ramp up, then disable ramps to zero
        cmd(SETP, 4'h3, 16'h0010);
        @(negedge clk_in);
        ch0_in = 16'sh0035;
        repeat (2) @(posedge clk_in);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            #1 check($sformatf("ramp_up%0d", i), DAC0_out, ramp_up[i]);
        end
        cmd(SETP, 4'h8, 16'h0002);
        @(posedge clk_in);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1 check($sformatf("ramp_dn%0d", i), DAC0_out, ramp_dn[i]);
        end

        // STEP >= 8000 behaves as 7FFF: a full-scale move takes two cycles
        cmd(SETP, 4'h3, 16'h8000);
        @(negedge clk_in);
        ch0_in = 16'sh8000;
        cmd(SETP, 4'h8, 16'h0003);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 check("bigstep_first", DAC0_out, 16'h8001);
        @(posedge clk_in);
        #1 check("bigstep_second", DAC0_out, 16'h8000);

        // Reset in the middle of a slow ramp
        cmd(SETP, 4'h3, 16'h0010);
        @(negedge clk_in);
        ch0_in = 16'sh0100;
        repeat (6) @(posedge clk_in);
        rd_check("pre_reset_ctrl", 4'h8, 16'h0003);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("midramp_rst_dac0", DAC0_out, 16'h0000);
        check("midramp_rst_dac1", DAC1_out, 16'h0000);
        check("midramp_rst_sat", {14'd0, sat_out}, 16'h0000);
        check("midramp_rst_cmd_data", cmd_data_out, 16'h0000);
        @(negedge clk_in);
        rst_in = 1'b1;
        rd_check("post_rst_off0", 4'h0, 16'h0000);
        rd_check("post_rst_step0", 4'h3, 16'h0000);
        rd_check("post_rst_min1", 4'h5, 16'h8000);
        rd_check("post_rst_max1", 4'h6, 16'h7FFF);
        rd_check("post_rst_ctrl", 4'h8, 16'h0003);
        rd_check("post_rst_status", 4'h9, 16'h0000);
        check("post_rst_restart", DAC0_out, 16'h0100);

        // Foreign prefix is ignored for both set and get
        rd_check("rd_max0_before_bad", 4'h2, 16'h7FFF);
        cmd(8'h24, 4'h0, 16'h1234);
        check("bad_prefix_hold", cmd_data_out, 16'h7FFF);
        rd_check("bad_prefix_no_write", 4'h0, 16'h0000);
        rd_check("reserved_reads_zero", 4'hC, 16'h0000);

        // Exactly five saturated samples on ch0
        cmd(SETP, 4'h0, 16'h7000);
        @(negedge clk_in);
        ch0_in = 16'sh0000;
        cmd(SETP, 4'hA, 16'h0000);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        ch0_in = 16'sh2000;
        repeat (5) @(negedge clk_in);
        ch0_in = 16'sh0000;
        repeat (6) @(posedge clk_in);
        rd_check("satcnt0_value", 4'hA, cnt_exp);
        cmd(SETP, 4'hA, 16'h0000);
        rd_check("satcnt0_cleared", 4'hA, 16'h0000);
        rd_check("satcnt1_value", 4'hB, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dac_output_conditioner.md
Name: dac_output_conditioner

Overview:
- Sits directly upstream of the AD9117 DAC driver and produces its two signed 16-bit sample inputs, DAC0 and DAC1.
- Per channel it applies a programmable offset, saturates the result to programmable min/max limits, and slew-rate limits it.
- Runtime configuration uses the standard cmd_trig/cmd_addr/cmd_data bus: address prefix 0x22 reads a register, 0x23 writes one.
- Fixed 3-cycle pipeline at the system clock rate.

Parameters:
- GET_PREFIX, 8'h22, cmd_addr_in[15:8] value that selects a register read.
- SET_PREFIX, 8'h23, cmd_addr_in[15:8] value that selects a register write.
- CTRL_RESET, 2'b11, reset value of the channel-enable bits.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_in  input  1  reset; synchronous, active-low.
- cmd_trig_in  input  1  one-cycle command strobe.
- cmd_addr_in  input  16  [15:8] prefix, [3:0] register index.
- cmd_data_in  input  16  write data.
- cmd_data_out  output  16  read data.
- ch0_in  input  16  signed sample, channel 0.
- ch1_in  input  16  signed sample, channel 1.
- DAC0_out  output  16  signed conditioned sample, channel 0; feeds the AD9117 DAC0 input.
- DAC1_out  output  16  signed conditioned sample, channel 1; feeds the AD9117 DAC1 input.
- sat_out  output  2  per-channel live saturation flag, aligned with DAC*_out.

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - DAC0_out, DAC1_out, sat_out and cmd_data_out all go to 0.
  - All pipeline registers clear.
  - Register file returns to its reset values.
  - Reset mid-ramp abandons the ramp; the output restarts from 0.
- Register map, indexed by cmd_addr_in[3:0]; channel c uses base 4c:
  - 0x0 / 0x4 OFFSET: signed; reset 0.
  - 0x1 / 0x5 MIN: signed; reset 16'h8000.
  - 0x2 / 0x6 MAX: signed; reset 16'h7FFF.
  - 0x3 / 0x7 STEP: unsigned maximum change per cycle; reset 0 = slew limiting bypassed.
  - 0x8 CTRL: [1:0] channel enable; reset CTRL_RESET; other bits read 0.
  - 0x9 STATUS: [1:0] sticky saturation flags; write-1-to-clear.
  - 0xA / 0xB: saturation counters (see Optional Feature).
  - 0xC–0xF: reserved; reads return 0, writes are ignored.
- Command handling:
  - Set: on the cycle cmd_trig_in=1 and prefix==SET_PREFIX, the register is written and takes effect for the sample in stage 1 on the next cycle.
  - Get: on the cycle cmd_trig_in=1 and prefix==GET_PREFIX, cmd_data_out is updated on the following edge and holds until the next get.
  - Triggers with any other prefix are ignored.
  - If a STATUS write-1-to-clear coincides with a new saturation event on the same channel, the set wins.
- Stage 1: sum = sign-extend17(ch_in) + sign-extend17(OFFSET), 17 bits, so it cannot overflow.
- Stage 2: clamp.
  - If the channel is disabled, target = 0 and the saturation flag = 0.
  - Otherwise: if sum > MAX, target = MAX; then if the result < MIN, target = MIN. When MIN > MAX, MIN therefore wins.
  - Saturation flag = 1 whenever the clamp changed the value.
- Stage 3: slew limit.
  - If STEP = 0: out = target.
  - Otherwise compute d = target − out in 17 bits.
  - If d > STEP: out += STEP.
  - If d < −STEP: out −= STEP.
  - Otherwise: out = target.
  - STEP values ≥ 16'h8000 are treated as 16'h7FFF.
  - The output never overshoots the target and never wraps.
- sat_out is delayed so it is aligned with DAC*_out; the STATUS sticky bits are set from the stage-2 flag.
- Latency from ch*_in to DAC*_out is 3 cycles with STEP = 0.
- Disabling a channel ramps its output to 0 at the STEP rate; with STEP = 0 the output goes to 0 immediately, after the pipeline delay.

Optional Feature:
- Macro: DAC_COND_SAT_CNT_EN.
- Defined:
  - Two 16-bit counters at 0xA (ch0) and 0xB (ch1) increment on every cycle the stage-2 saturation flag is 1.
  - The counters saturate at 16'hFFFF; they do not wrap.
  - Any write to 0xA or 0xB clears that counter; reset clears both.
- Undefined: no counter logic is built; 0xA and 0xB read 0 and writes to them are ignored.

Test Plan:
- After reset, ch0_in = 16'h1234 constant → DAC0_out = 16'h1234 on the third edge after the input is applied; read of 0x8 returns 16'h0003; read of 0x2 returns 16'h7FFF.
- Write 0x0 = 16'h7000, ch0_in = 16'h2000 → DAC0_out = 16'h7FFF, sat_out[0] = 1, STATUS[0] = 1. Writing STATUS = 1 clears it only once the input is back in range.
- Write MIN = 16'h0100 and MAX = 16'h00F0 (MIN > MAX), ch1_in = 0 → DAC1_out = 16'h0100.
- Write STEP0 = 16'h0010, step ch0_in from 0 to 16'h0035 → DAC0_out sequence 0x10, 0x20, 0x30, 0x35, then holds. Clearing CTRL[0] → output ramps 0x25, 0x15, 0x05, 0.
- Assert rst_in = 0 mid-ramp → next edge DAC*_out = 0 and all registers read their reset values; set/get with prefix 0x24 → no register change and cmd_data_out unchanged.
- With DAC_COND_SAT_CNT_EN defined, 5 cycles of saturation on ch0 → read 0xA = 5; a write to 0xA → 0. Without the macro → 0xA reads 0.
